dwiz_interlock: RTL and testbench
=================================

# dwiz_interlock

Pipeline interlock unit for the five-stage MIPS core. Operand bypassing resolves most data hazards, but some cases cannot be covered by forwarding. This block detects those cases and holds the front of the pipeline:
- load-use hazards;
- ID-stage branch operand hazards;
- accesses to the multi-cycle multiply/divide unit (MDU) and HI/LO while it is busy.

The block stalls PC and IF/ID, injects a bubble into ID/EX, tracks MDU occupancy with a countdown state machine, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles the MDU stays busy after accepting mult/multu
- DIV_CYCLES, 32, cycles the MDU stays busy after accepting div/divu

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- id_rs  input  5  rs field of instruction in ID
- id_rt  input  5  rt field of instruction in ID
- id_rs_used  input  1  ID instruction reads rs
- id_rt_used  input  1  ID instruction reads rt
- id_branch  input  1  ID instruction is a branch/jr that compares or reads registers in ID
- id_mdu_op  input  2  00 none, 01 mult/multu, 10 div/divu, 11 reserved (treated as none)
- id_hilo_read  input  1  ID instruction is mfhi/mflo
- id2exRd  input  5  destination register of instruction in EX
- id2exRegWrite  input  1  EX instruction writes a register
- id2exMemRead  input  1  EX instruction is a load
- ex2memRd  input  5  destination register of instruction in MEM
- ex2memMemRead  input  1  MEM instruction is a load
- pc_stall  output  1  hold PC
- if2id_stall  output  1  hold IF/ID register
- id2ex_bubble  output  1  load NOP into ID/EX
- mdu_busy  output  1  MDU occupied
- stall_count  output  32  total stalled cycles since reset

## Operation
- match_rs(r): (r != 0) & id_rs_used & (r == id_rs). match_rt(r) is defined the same way with rt. match(r) = match_rs(r) | match_rt(r).
- load_use = id2exMemRead & match(id2exRd).
- branch_haz = id_branch & ((id2exRegWrite & match(id2exRd)) | (ex2memMemRead & match(ex2memRd))).
- mdu_haz = mdu_busy & ((id_mdu_op is 01 or 10) | id_hilo_read).
- stall = load_use | branch_haz | mdu_haz.
- pc_stall = if2id_stall = id2ex_bubble = stall. These outputs are combinational, so they take effect in the same cycle.
- MDU state machine: two states, IDLE (busy_cnt == 0) and BUSY (busy_cnt != 0). mdu_busy = (busy_cnt != 0). busy_cnt is 6 bits wide.
  - IDLE -> BUSY: when id_mdu_op is 01 and stall == 0, load busy_cnt = MULT_CYCLES. When id_mdu_op is 10 and stall == 0, load busy_cnt = DIV_CYCLES. This is the accept cycle.
  - BUSY: decrement busy_cnt by 1 each cycle. BUSY -> IDLE when busy_cnt reaches 0.
  - An MDU op is never accepted while BUSY; it stalls through mdu_haz. An MDU op is never accepted while stall is high for any other cause, because the instruction does not advance.
- stall_count: increments by 1 in every cycle where stall == 1. It saturates at 0xFFFFFFFF and does not wrap.

## Timing
- Reset: busy_cnt = 0, mdu_busy = 0, stall_count = 0. After reset, stall outputs depend only on the combinational hazard terms.
- rst asserted mid-operation, including during a divide: busy_cnt clears to 0 on that edge. mdu_busy = 0 from the next cycle.
- Accept at cycle T: mdu_busy is high from T+1 through T+MULT_CYCLES (mult) or T+DIV_CYCLES (div). It is low at the next cycle after that.
- An mfhi in ID at cycle T+1 after a mult is accepted at T stalls cycles T+1..T+5 and advances at T+6.
- A new MDU op in ID during the last busy cycle (busy_cnt == 1) still stalls. It is accepted the following cycle, when busy_cnt == 0.
- Simultaneous hazards are OR-ed. stall_count increments once per cycle regardless of how many causes are active.
- Register $0 never causes a stall.

## Test plan
- lw $5 in EX (id2exMemRead=1, id2exRd=5); add with rs=5 in ID -> stall=1 for exactly 1 cycle, stall_count=1. The same sequence with rd=0 -> no stall.
- beq rs=7 in ID, id2exRegWrite=1, id2exRd=7 -> stall for 1 cycle. Next cycle: ex2memMemRead=0, ex2memRd=7 -> no stall. With ex2memMemRead=1 -> a second stall cycle.
- mult accepted at T, mflo in ID at T+1 -> stall high T+1..T+5, low at T+6, mdu_busy low at T+6, stall_count=5.
- div accepted, then a second div in ID -> 32 stall cycles, accepted on cycle 33, mdu_busy high for a further 32 cycles.
- div accepted, rst pulsed at busy_cnt=20 -> next cycle mdu_busy=0, stall_count=0, and mfhi in ID does not stall.
- Force stall_count to 0xFFFFFFFE (via a long stall run or a bench backdoor), then hold stall for 3 cycles -> stall_count stays at 0xFFFFFFFF.

Source files
------------

// File: rtl/dwiz_interlock_if.sv
// rtl/dwiz_interlock_if.sv - hazard-detection signal bundle between the MIPS pipeline and dwiz_interlock
// Purpose: groups the ID/EX/MEM hazard inputs and the stall/bubble/monitor outputs.
// Ports (as seen by the interlock, modport slave):
//   in : id_rs, id_rt, id_rs_used, id_rt_used, id_branch, id_mdu_op, id_hilo_read,
//        id2exRd, id2exRegWrite, id2exMemRead, ex2memRd, ex2memMemRead
//   out: pc_stall, if2id_stall, id2ex_bubble, mdu_busy, stall_count
interface dwiz_interlock_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        id_branch;
  logic [1:0]  id_mdu_op;
  logic        id_hilo_read;
  logic [4:0]  id2exRd;
  logic        id2exRegWrite;
  logic        id2exMemRead;
  logic [4:0]  ex2memRd;
  logic        ex2memMemRead;
  logic        pc_stall;
  logic        if2id_stall;
  logic        id2ex_bubble;
  logic        mdu_busy;
  logic [31:0] stall_count;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, id_branch, id_mdu_op, id_hilo_read,
           id2exRd, id2exRegWrite, id2exMemRead, ex2memRd, ex2memMemRead,
    input  pc_stall, if2id_stall, id2ex_bubble, mdu_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, id_branch, id_mdu_op, id_hilo_read,
           id2exRd, id2exRegWrite, id2exMemRead, ex2memRd, ex2memMemRead,
    output pc_stall, if2id_stall, id2ex_bubble, mdu_busy, stall_count
  );
endinterface

// File: rtl/dwiz_interlock.sv
// rtl/dwiz_interlock.sv - pipeline interlock: load-use, ID branch operand and MDU busy stalls
// Purpose: detects hazards that forwarding cannot cover, holds PC and IF/ID, bubbles ID/EX,
//          tracks MDU occupancy with a countdown FSM and counts stalled cycles (saturating).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   bus  - dwiz_interlock_if.slave (hazard inputs, stall/bubble/mdu_busy/stall_count outputs)
module dwiz_interlock #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 32
) (
  input logic            clk,
  input logic            rst,
  dwiz_interlock_if.slave bus
);

  typedef enum logic {IDLE, BUSY} mduState_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES);

  mduState_t   state;
  mduState_t   stateNext;
  logic [5:0]  busyCnt;
  logic [5:0]  busyCntNext;
  logic [31:0] stallCount;

  logic exMatch;
  logic memMatch;
  logic loadUse;
  logic branchHaz;
  logic mduHaz;
  logic mduOp;
  logic stall;

  // $0 is hardwired to zero, so it can never carry a real dependency.
  assign exMatch  = (bus.id2exRd != 5'd0) &&
                    ((bus.id_rs_used && (bus.id2exRd == bus.id_rs)) ||
                     (bus.id_rt_used && (bus.id2exRd == bus.id_rt)));
  assign memMatch = (bus.ex2memRd != 5'd0) &&
                    ((bus.id_rs_used && (bus.ex2memRd == bus.id_rs)) ||
                     (bus.id_rt_used && (bus.ex2memRd == bus.id_rt)));

  // Opcode 11 is reserved and behaves as "no MDU op".
  assign mduOp     = (bus.id_mdu_op == 2'b01) || (bus.id_mdu_op == 2'b10);
  assign loadUse   = bus.id2exMemRead && exMatch;
  assign branchHaz = bus.id_branch &&
                     ((bus.id2exRegWrite && exMatch) || (bus.ex2memMemRead && memMatch));
  assign mduHaz    = (busyCnt != 6'd0) && (mduOp || bus.id_hilo_read);
  assign stall     = loadUse || branchHaz || mduHaz;

  assign bus.pc_stall     = stall;
  assign bus.if2id_stall  = stall;
  assign bus.id2ex_bubble = stall;
  assign bus.mdu_busy     = (busyCnt != 6'd0);
  assign bus.stall_count  = stallCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busyCnt <= 6'd0;
    end else begin
      state   <= stateNext;
      busyCnt <= busyCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    busyCntNext = busyCnt;
    case (state)
      IDLE: begin
        // An op only leaves ID (is accepted) when nothing else holds the pipe.
        if (!stall) begin
          if (bus.id_mdu_op == 2'b01) begin
            busyCntNext = MULT_LOAD;
          end else if (bus.id_mdu_op == 2'b10) begin
            busyCntNext = DIV_LOAD;
          end
        end
      end
      BUSY: begin
        busyCntNext = busyCnt - 6'd1;
      end
      default: begin
        busyCntNext = 6'd0;
      end
    endcase
    // State always mirrors whether the countdown is non-zero.
    stateNext = (busyCntNext != 6'd0) ? BUSY : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCount <= 32'd0;
    end else if (stall && (stallCount != 32'hFFFF_FFFF)) begin
      stallCount <= stallCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_dwiz_interlock.sv
// tb/tb_dwiz_interlock.sv - directed self-checking bench for dwiz_interlock
module tb_dwiz_interlock;
  logic clk;
  logic rst;
  int checks;
  int failures;

  dwiz_interlock_if ifc();

  dwiz_interlock #(.MULT_CYCLES(5), .DIV_CYCLES(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clearIn();
    ifc.id_rs = 5'd0; ifc.id_rt = 5'd0; ifc.id_rs_used = 1'b0; ifc.id_rt_used = 1'b0;
    ifc.id_branch = 1'b0; ifc.id_mdu_op = 2'b00; ifc.id_hilo_read = 1'b0;
    ifc.id2exRd = 5'd0; ifc.id2exRegWrite = 1'b0; ifc.id2exMemRead = 1'b0;
    ifc.ex2memRd = 5'd0; ifc.ex2memMemRead = 1'b0;
  endtask

  task automatic doReset();
    clearIn();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    settle();
    checks++; if (ifc.mdu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ifc.mdu_busy); end
    checks++; if (ifc.stall_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ifc.stall_count); end
    checks++; if ({ifc.pc_stall, ifc.if2id_stall, ifc.id2ex_bubble} !== 3'b000) begin failures++; $display("FAIL reset_stall got=%b exp=000", {ifc.pc_stall, ifc.if2id_stall, ifc.id2ex_bubble}); end
    tick();
  endtask

  task automatic test_load_use();
    doReset();
    ifc.id2exMemRead = 1'b1; ifc.id2exRd = 5'd5; ifc.id_rs = 5'd5; ifc.id_rs_used = 1'b1;
    settle();
    checks++; if ({ifc.pc_stall, ifc.if2id_stall, ifc.id2ex_bubble} !== 3'b111) begin failures++; $display("FAIL lu_stall got=%b exp=111", {ifc.pc_stall, ifc.if2id_stall, ifc.id2ex_bubble}); end
    tick();
    ifc.id2exMemRead = 1'b0; ifc.id2exRd = 5'd0;
    settle();
    checks++; if (ifc.pc_stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", ifc.pc_stall); end
    checks++; if (ifc.stall_count !== 32'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", ifc.stall_count); end
    // rt operand also matches
    ifc.id2exMemRead = 1'b1; ifc.id2exRd = 5'd9; ifc.id_rt = 5'd9; ifc.id_rt_used = 1'b1;
    settle();
    checks++; if (ifc.pc_stall !== 1'b1) begin failures++; $display("FAIL lu_rt got=%b exp=1", ifc.pc_stall); end
    // rt match but rt not read
    ifc.id_rt_used = 1'b0;
    settle();
    checks++; if (ifc.pc_stall !== 1'b0) begin failures++; $display("FAIL lu_rt_unused got=%b exp=0", ifc.pc_stall); end
    // $0 never stalls
    clearIn();
    ifc.id2exMemRead = 1'b1; ifc.id2exRd = 5'd0; ifc.id_rs = 5'd0; ifc.id_rs_used = 1'b1;
    settle();
    checks++; if (ifc.pc_stall !== 1'b0) begin failures++; $display("FAIL lu_r0 got=%b exp=0", ifc.pc_stall); end
    tick();
    checks++; if (ifc.stall_count !== 32'd1) begin failures++; $display("FAIL lu_r0_count got=%0d exp=1", ifc.stall_count); end
  endtask

  task automatic test_branch();
    doReset();
    ifc.id_branch = 1'b1; ifc.id_rs = 5'd7; ifc.id_rs_used = 1'b1;
    ifc.id2exRegWrite = 1'b1; ifc.id2exRd = 5'd7;
    settle();
    checks++; if (ifc.pc_stall !== 1'b1) begin failures++; $display("FAIL br_ex got=%b exp=1", ifc.pc_stall); end
    tick();
    ifc.id2exRegWrite = 1'b0; ifc.id2exRd = 5'd0; ifc.ex2memRd = 5'd7; ifc.ex2memMemRead = 1'b0;
    settle();
    checks++; if (ifc.pc_stall !== 1'b0) begin failures++; $display("FAIL br_mem_alu got=%b exp=0", ifc.pc_stall); end
    ifc.ex2memMemRead = 1'b1;
    settle();
    checks++; if (ifc.pc_stall !== 1'b1) begin failures++; $display("FAIL br_mem_load got=%b exp=1", ifc.pc_stall); end
    tick();
    checks++; if (ifc.stall_count !== 32'd2) begin failures++; $display("FAIL br_count got=%0d exp=2", ifc.stall_count); end
    // same operands without a branch: no hazard
    ifc.id_branch = 1'b0;
    settle();
    checks++; if (ifc.pc_stall !== 1'b0) begin failures++; $display("FAIL br_nobranch got=%b exp=0", ifc.pc_stall); end
    tick();
  endtask

  task automatic test_mult();
    doReset();
    ifc.id_mdu_op = 2'b01;
    settle();
    checks++; if (ifc.pc_stall !== 1'b0) begin failures++; $display("FAIL mult_accept got=%b exp=0", ifc.pc_stall); end
    tick();
    ifc.id_mdu_op = 2'b00; ifc.id_hilo_read = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      settle();
      checks++; if ({ifc.pc_stall, ifc.mdu_busy} !== 2'b11) begin failures++; $display("FAIL mult_busy_%0d got=%b exp=11", i, {ifc.pc_stall, ifc.mdu_busy}); end
      tick();
    end
    settle();
    checks++; if ({ifc.pc_stall, ifc.mdu_busy} !== 2'b00) begin failures++; $display("FAIL mult_done got=%b exp=00", {ifc.pc_stall, ifc.mdu_busy}); end
    checks++; if (ifc.stall_count !== 32'd5) begin failures++; $display("FAIL mult_count got=%0d exp=5", ifc.stall_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    doReset();
    ifc.id_mdu_op = 2'b10;
    tick();
    for (int i = 1; i <= 32; i++) begin
      settle();
      checks++; if ({ifc.pc_stall, ifc.mdu_busy} !== 2'b11) begin failures++; $display("FAIL div2_wait_%0d got=%b exp=11", i, {ifc.pc_stall, ifc.mdu_busy}); end
      tick();
    end
    settle();
    checks++; if ({ifc.pc_stall, ifc.mdu_busy} !== 2'b00) begin failures++; $display("FAIL div2_accept got=%b exp=00", {ifc.pc_stall, ifc.mdu_busy}); end
    checks++; if (ifc.stall_count !== 32'd32) begin failures++; $display("FAIL div2_count got=%0d exp=32", ifc.stall_count); end
    tick();
    ifc.id_mdu_op = 2'b00;
    for (int i = 1; i <= 32; i++) begin
      settle();
      checks++; if (ifc.mdu_busy !== 1'b1) begin failures++; $display("FAIL div2_busy_%0d got=%b exp=1", i, ifc.mdu_busy); end
      tick();
    end
    settle();
    checks++; if (ifc.mdu_busy !== 1'b0) begin failures++; $display("FAIL div2_idle got=%b exp=0", ifc.mdu_busy); end
    checks++; if (ifc.stall_count !== 32'd32) begin failures++; $display("FAIL div2_count_end got=%0d exp=32", ifc.stall_count); end
    tick();
  endtask

  task automatic test_rst_mid_div();
    doReset();
    ifc.id_mdu_op = 2'b10;
    tick();
    // busy_cnt 32 now; stall on mfhi while counting down to 20
    ifc.id_mdu_op = 2'b00; ifc.id_hilo_read = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    settle();
    checks++; if (ifc.stall_count !== 32'd12) begin failures++; $display("FAIL rdiv_precount got=%0d exp=12", ifc.stall_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    checks++; if (ifc.mdu_busy !== 1'b0) begin failures++; $display("FAIL rdiv_busy got=%b exp=0", ifc.mdu_busy); end
    checks++; if (ifc.stall_count !== 32'd0) begin failures++; $display("FAIL rdiv_count got=%0d exp=0", ifc.stall_count); end
    checks++; if (ifc.pc_stall !== 1'b0) begin failures++; $display("FAIL rdiv_mfhi got=%b exp=0", ifc.pc_stall); end
    tick();
  endtask

  task automatic test_other_causes();
    doReset();
    // mult blocked by a load-use hazard is not accepted
    ifc.id_mdu_op = 2'b01; ifc.id2exMemRead = 1'b1; ifc.id2exRd = 5'd3; ifc.id_rs = 5'd3; ifc.id_rs_used = 1'b1;
    tick();
    settle();
    checks++; if (ifc.mdu_busy !== 1'b0) begin failures++; $display("FAIL blocked_mult got=%b exp=0", ifc.mdu_busy); end
    // reserved opcode is never accepted
    clearIn();
    ifc.id_mdu_op = 2'b11;
    tick();
    settle();
    checks++; if (ifc.mdu_busy !== 1'b0) begin failures++; $display("FAIL reserved_op got=%b exp=0", ifc.mdu_busy); end
    // mult accepted, then load-use and MDU hazard together count once
    ifc.id_mdu_op = 2'b01;
    tick();
    ifc.id_mdu_op = 2'b00; ifc.id_hilo_read = 1'b1;
    ifc.id2exMemRead = 1'b1; ifc.id2exRd = 5'd4; ifc.id_rs = 5'd4; ifc.id_rs_used = 1'b1;
    tick();
    settle();
    checks++; if (ifc.stall_count !== 32'd2) begin failures++; $display("FAIL overlap_count got=%0d exp=2", ifc.stall_count); end
    clearIn();
    tick();
  endtask

  task automatic test_saturate();
    doReset();
    dut.stallCount = 32'hFFFF_FFFE;
    ifc.id2exMemRead = 1'b1; ifc.id2exRd = 5'd6; ifc.id_rt = 5'd6; ifc.id_rt_used = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      settle();
      checks++; if (ifc.stall_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_%0d got=%h exp=ffffffff", i, ifc.stall_count); end
    end
    clearIn();
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    clearIn();
    tick();
    test_reset();
    test_load_use();
    test_branch();
    test_mult();
    test_back_to_back();
    test_rst_mid_div();
    test_other_causes();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
